// File: rtl/serv_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serv_rf_pkg
// Description : Shared types and helpers for the SERV register-file RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package serv_rf_pkg;

    localparam int GPR_COUNT = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Words needed to hold all GPRs plus CSR shadows, each 32 bits wide
    function automatic int rf_depth(input int width, input int csr_regs);
        return (GPR_COUNT + csr_regs) * 32 / width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serv_rf_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : serv_rf_ram_array
// Description : Plain synchronous-read memory, no reset, block-RAM friendly.
// Revision    : 1.0 - initial release
// ============================================================================
module serv_rf_ram_array #(
    parameter int DW    = 3,
    parameter int DEPTH = 576,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/serv_rf_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serv_rf_ram_ctrl
// Description : SERV RF RAM with zero-fill sweep, ready, write-first bypass.
//               Optional parity check enabled by SERV_RF_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serv_rf_ram_ctrl
    import serv_rf_pkg::*;
#(
    parameter int WIDTH          = 2,
    parameter int CSR_REGS       = 4,
    parameter int DEPTH          = rf_depth(WIDTH, CSR_REGS),
    parameter int AW             = $clog2(DEPTH),
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr_req,
    output logic             o_ready,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_perr
);

`ifdef SERV_RF_PARITY_EN
    localparam int c_dw = WIDTH + 1;
`else
    localparam int c_dw = WIDTH;
`endif
    localparam logic [AW:0]   c_depth     = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] c_last      = AW'(DEPTH - 1);
    localparam state_t        c_rst_state = CLEAR_ON_RESET ? CLEAR : READY;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_clr_cnt;
    logic              w_ready;
    logic              w_sweep;
    logic              w_clr_start;
    logic              w_waddr_ok;
    logic              w_raddr_ok;
    logic              w_byp;
    logic              w_ram_we;
    logic [AW-1:0]     w_ram_waddr;
    logic [c_dw-1:0]   w_ram_wdata;
    logic [c_dw-1:0]   w_ram_q;
    logic              r_rd_mem;
    logic              r_rd_byp;
    logic [WIDTH-1:0]  r_byp_data;
    logic [WIDTH-1:0]  w_rdata;

    assign w_ready     = (r_state == READY);
    assign w_sweep     = (r_state == CLEAR);
    assign w_clr_start = w_ready & i_clr_req;
    assign w_waddr_ok  = ({1'b0, i_waddr} < c_depth);
    assign w_raddr_ok  = ({1'b0, i_raddr} < c_depth);
    assign w_byp       = i_wen & (i_waddr == i_raddr) & w_raddr_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_rst_state;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (r_clr_cnt == c_last) w_state_nxt = READY;
            READY:   if (i_clr_req) w_state_nxt = CLEAR;
            default: w_state_nxt = r_state;
        endcase
    end

    // Counter parks on the last address once the sweep is done
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_cnt <= '0;
        end else if (w_clr_start) begin
            r_clr_cnt <= '0;
        end else if (w_sweep && (r_clr_cnt != c_last)) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    always_comb begin
        w_ram_we    = w_sweep | (w_ready & i_wen & w_waddr_ok);
        w_ram_waddr = w_sweep ? r_clr_cnt : i_waddr;
        w_ram_wdata = '0;
        if (!w_sweep) begin
`ifdef SERV_RF_PARITY_EN
            w_ram_wdata = {^i_wdata, i_wdata};
`else
            w_ram_wdata = i_wdata;
`endif
        end
    end

    serv_rf_ram_array #(
        .DW    (c_dw),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (i_raddr),
        .o_rdata (w_ram_q)
    );

    // Select flags are registered so o_rdata is a mux of flops only
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_mem   <= 1'b0;
            r_rd_byp   <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_rd_mem   <= w_ready & w_raddr_ok & ~w_byp;
            r_rd_byp   <= w_ready & w_byp;
            r_byp_data <= i_wdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_ready) begin
            if (r_rd_byp) begin
                w_rdata = r_byp_data;
            end else if (r_rd_mem) begin
                w_rdata = w_ram_q[WIDTH-1:0];
            end
        end
    end

    assign o_rdata = w_rdata;
    assign o_ready = w_ready;

`ifdef SERV_RF_PARITY_EN
    logic r_perr;

    // Stored bit is even parity, so a clean word XORs to zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perr <= 1'b0;
        end else if (w_clr_start) begin
            r_perr <= 1'b0;
        end else if (w_ready && r_rd_mem && (^w_ram_q)) begin
            r_perr <= 1'b1;
        end
    end

    assign o_perr = r_perr;
`else
    assign o_perr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serv_rf_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serv_rf_ram_ctrl
// Description : Self-checking bench for serv_rf_ram_ctrl (WIDTH=2, CSR_REGS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serv_rf_ram_ctrl;

    localparam int WIDTH = 2;
    localparam int CSR_REGS = 4;
    localparam int DEPTH = 576;
    localparam int AW = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_req = 1'b0;
    logic             ready;
    logic [AW-1:0]    waddr = '0;
    logic [WIDTH-1:0] wdata = '0;
    logic             wen = 1'b0;
    logic [AW-1:0]    raddr = '0;
    logic [WIDTH-1:0] rdata;
    logic             perr;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model [DEPTH];

    typedef struct {
        bit we;
        int wa;
        int wd;
        int ra;
        int exp;
    } vec_t;

    vec_t vecs [14];

    serv_rf_ram_ctrl #(
        .WIDTH          (WIDTH),
        .CSR_REGS       (CSR_REGS),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_clr_req (clr_req),
        .o_ready   (ready),
        .i_waddr   (waddr),
        .i_wdata   (wdata),
        .i_wen     (wen),
        .i_raddr   (raddr),
        .o_rdata   (rdata),
        .o_perr    (perr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Reference read: out of range is zero, same-cycle write wins, else stored
    function automatic int model_read(input int ra, input int wa, input bit we, input int wd);
        if (ra >= DEPTH) return 0;
        if (we && wa == ra) return wd;
        return int'(model[ra]);
    endfunction

    task automatic cycle_model(input bit we, input int wa, input int wd, input int ra, input string nm);
        int exp;
        wen   = we;
        waddr = AW'(wa);
        wdata = WIDTH'(wd);
        raddr = AW'(ra);
        exp   = model_read(ra, wa, we, wd);
        step();
        check(nm, int'(rdata), exp);
        if (we && wa < DEPTH) model[wa] = WIDTH'(wd);
        wen = 1'b0;
    endtask

    task automatic wait_ready(input int inj_at, output int n, output bit nz);
        n  = 0;
        nz = 1'b0;
        while (!ready && n < 2000) begin
            if (n == inj_at) begin
                wen = 1'b1; waddr = AW'(5); wdata = 2'd3;
            end else begin
                wen = 1'b0;
            end
            step();
            n++;
            if (!ready && rdata != '0) nz = 1'b1;
        end
        wen = 1'b0;
    endtask

    initial begin
        int  n;
        bit  nz;
        int  wa, ra, wd;
        bit  we;

        vecs[0]  = '{1'b1,    5, 2,    0, 0};
        vecs[1]  = '{1'b0,    0, 0,    5, 2};
        vecs[2]  = '{1'b1,    9, 1,    9, 1};
        vecs[3]  = '{1'b0,    0, 0,    9, 1};
        vecs[4]  = '{1'b1,  600, 3,  600, 0};
        vecs[5]  = '{1'b0,    0, 0,  600, 0};
        vecs[6]  = '{1'b1,  575, 3,    5, 2};
        vecs[7]  = '{1'b0,    0, 0,  575, 3};
        vecs[8]  = '{1'b1,  100, 3,  575, 3};
        vecs[9]  = '{1'b0,    0, 0,  100, 3};
        vecs[10] = '{1'b1, 1023, 2,    9, 1};
        vecs[11] = '{1'b0,    0, 0, 1023, 0};
        vecs[12] = '{1'b0,    0, 0,   88, 0};
        vecs[13] = '{1'b0,    0, 0,  511, 0};

        // Reset state
        repeat (3) step();
        check("reset_ready", int'(ready), 0);
        check("reset_rdata", int'(rdata), 0);
        check("reset_perr", int'(perr), 0);
        rst_n = 1'b1;
        wait_ready(-1, n, nz);
        check("sweep_len_after_reset", n, DEPTH);
        check("rdata_zero_in_sweep", int'(nz), 0);
        model_clear();
        cycle_model(1'b0, 0, 0, 0, "read_0_after_sweep");
        cycle_model(1'b0, 0, 0, 287, "read_287_after_sweep");
        cycle_model(1'b0, 0, 0, 575, "read_575_after_sweep");

        // Directed vectors: write/read, bypass, out-of-range handling
        for (int i = 0; i < 14; i++) begin
            wen   = vecs[i].we;
            waddr = AW'(vecs[i].wa);
            wdata = WIDTH'(vecs[i].wd);
            raddr = AW'(vecs[i].ra);
            step();
            check($sformatf("vec%0d_rdata", i), int'(rdata), vecs[i].exp);
            if (vecs[i].we && vecs[i].wa < DEPTH) model[vecs[i].wa] = WIDTH'(vecs[i].wd);
            wen = 1'b0;
        end

        // Runtime clear with a write attempted late in the sweep
        clr_req = 1'b1;
        raddr   = AW'(5);
        step();
        clr_req = 1'b0;
        check("ready_drops_on_clr", int'(ready), 0);
        wait_ready(570, n, nz);
        check("sweep_len_after_clr", n, DEPTH);
        check("rdata_zero_in_clr", int'(nz), 0);
        model_clear();
        cycle_model(1'b0, 0, 0, 100, "read_100_after_clr");
        cycle_model(1'b0, 0, 0, 5, "dropped_write_addr5");

        // Asynchronous reset while READY with nonzero read data
        cycle_model(1'b1, 50, 3, 0, "write_50");
        cycle_model(1'b0, 0, 0, 50, "read_50");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", int'(ready), 0);
        check("async_rst_rdata", int'(rdata), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(-1, n, nz);
        check("sweep_len_after_rst_ready", n, DEPTH);
        model_clear();
        cycle_model(1'b0, 0, 0, 50, "read_50_after_rst");

        // Reset 300 cycles into a sweep restarts it from address 0
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (300) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_sweep_rst_ready", int'(ready), 0);
        check("mid_sweep_rst_rdata", int'(rdata), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(-1, n, nz);
        check("sweep_len_after_mid_rst", n, DEPTH);
        model_clear();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) wa = ra;
            else if ($urandom_range(0, 3) == 0) wa = int'($urandom_range(0, 1023));
            else wa = int'($urandom_range(0, 15));
            wd = int'($urandom_range(0, 3));
            cycle_model(we, wa, wd, ra, "random_rdata");
        end
        check("perr_clean_after_random", int'(perr), 0);
        check("ready_after_random", int'(ready), 1);

`ifdef SERV_RF_PARITY_EN
        cycle_model(1'b1, 7, 1, 0, "parity_write_7");
        dut.u_ram.r_mem[7][0] = ~dut.u_ram.r_mem[7][0];
        raddr = AW'(7);
        step();
        check("parity_flipped_rdata", int'(rdata), 0);
        check("parity_perr_not_yet", int'(perr), 0);
        step();
        check("parity_perr_set", int'(perr), 1);
        raddr = AW'(0);
        repeat (5) step();
        check("parity_perr_sticky", int'(perr), 1);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("parity_perr_cleared", int'(perr), 0);
        wait_ready(-1, n, nz);
        check("sweep_len_after_parity", n, DEPTH);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serv_rf_ram_ctrl.md
Name: serv_rf_ram_ctrl

Overview:
- Parametrised register-file RAM with controller for SERV-class cores.
- Sits behind serv_rf_ram_if: consumes its waddr/wdata/wen/raddr stream and returns rdata.
- Adds what a bare RAM lacks: a hardware zero-fill sweep after reset or on request, a ready handshake, a same-cycle write-to-read bypass, and an optional parity check.
- Replaces the external RF RAM that the synth wrapper currently leaves to the integrator.

Parameters:
- WIDTH, 2, RAM word width in bits (1, 2, 4, 8, 16 or 32).
- CSR_REGS, 4, number of CSR shadow registers stored after the 32 GPRs (0 or 4).
- DEPTH, (32+CSR_REGS)*32/WIDTH, number of words.
- AW, $clog2(DEPTH), address width.
- CLEAR_ON_RESET, 1: zero-fill sweep after reset. 0: RAM contents are undefined and the block is ready immediately.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_clr_req  in  1  pulse requesting a runtime zero-fill; honoured only in READY
- o_ready  out  1  high when the RAM accepts traffic
- i_waddr  in  AW  write address
- i_wdata  in  WIDTH  write data
- i_wen  in  1  write enable
- i_raddr  in  AW  read address
- o_rdata  out  WIDTH  read data, registered
- o_perr  out  1  sticky parity error; see SERV_RF_PARITY_EN

Behaviour:
- Reset values (asserted asynchronously):
  - o_ready = 0 if CLEAR_ON_RESET, else 1
  - o_rdata = 0, o_perr = 0
  - state = CLEAR if CLEAR_ON_RESET, else READY
  - clr_cnt = 0
  - RAM array is not reset.
- State machine: 2 states.
  - CLEAR:
    - Each cycle write 0 to mem[clr_cnt], then clr_cnt++.
    - When clr_cnt == DEPTH-1 is written, go to READY next cycle and assert o_ready.
    - Sweep duration is exactly DEPTH cycles after reset release.
  - READY:
    - i_clr_req=1 → CLEAR next cycle; o_ready drops next cycle; clr_cnt = 0.
- Effects of o_ready:
  - While o_ready=0, i_wen is ignored (no write) and o_rdata is forced to 0.
  - The caller must hold off; serv_rf_ram_if is gated via o_ready externally.
- Read:
  - o_rdata <= mem[i_raddr] on every clock edge in READY.
  - Latency: 1 cycle.
- Write: mem[i_waddr] <= i_wdata when i_wen && READY.
- Bypass: if i_wen && i_waddr == i_raddr in the same READY cycle, o_rdata <= i_wdata (write-first).
- i_clr_req while already in CLEAR: ignored; the sweep does not restart.
- Reset mid-sweep: clr_cnt returns to 0 and the sweep restarts from address 0.
- Addresses >= DEPTH (possible when DEPTH is not a power of two):
  - Writes are dropped.
  - Reads return 0.
- clr_cnt is AW bits wide and never wraps past DEPTH-1.

Optional Feature:
- Macro: SERV_RF_PARITY_EN
- Defined:
  - Each word stores WIDTH+1 bits; the extra bit is even parity of the data, written on every write including the sweep (parity of 0 = 0).
  - On each READY read, the stored parity is recomputed one cycle later alongside o_rdata.
  - A mismatch sets o_perr.
  - o_perr clears only on reset or on entry to CLEAR.
  - Bypassed reads are never flagged.
- Undefined:
  - Storage is WIDTH bits.
  - o_perr is tied to 0.
  - The port remains present.

Decomposition:
- Shared package serv_rf_pkg:
  - state enum {CLEAR, READY}
  - function rf_depth(width, csr_regs)
  - localparam GPR_COUNT = 32
- Sub-module serv_rf_ram_array: plain synchronous-read memory with parametrised width/depth and no reset, so synthesis infers block RAM.
- The controller holds the FSM, bypass mux and parity logic.

Test Plan:
1. Reset release with WIDTH=2, CSR_REGS=4 (DEPTH=576) → o_ready rises exactly 576 cycles later; reading addresses 0, 287 and 575 returns 0.
2. In READY, write 2'b10 to address 5, then read address 5 → o_rdata = 2'b10 one cycle after raddr is presented.
3. Same cycle: wen=1, waddr=raddr=9, wdata=2'b01 → next cycle o_rdata = 2'b01 (bypass). The following read of 9 returns 2'b01.
4. Pulse i_clr_req after writing 3 to address 100 → o_ready low for 576 cycles. A write attempted during CLEAR is dropped. Address 100 reads 0 afterwards.
5. Assert i_rst_n=0 at sweep cycle 300 → o_ready=0 and o_rdata=0 immediately; after release the full 576-cycle sweep repeats.
6. With SERV_RF_PARITY_EN, force-flip one stored data bit at address 7 via a hierarchical poke, then read address 7 → o_perr=1 one cycle after o_rdata updates and stays 1 until i_clr_req.
